// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// the small decode helpers used at request acceptance.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        READ   = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    function automatic logic is_illegal(input logic write, input logic [2:0] f3);
        if (write) begin
            return f3 > F3_W;
        end
        return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction

    // Access size lives in funct3[1:0] for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'd1:    return lo[0];
            2'd2:    return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'd0:    return 4'b0001 << lo;
            2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a 32-bit read word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] q,
    input  logic [1:0]  lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lo)
            2'd0:    byte_sel = q[7:0];
            2'd1:    byte_sel = q[15:8];
            2'd2:    byte_sel = q[23:16];
            default: byte_sel = q[31:24];
        endcase
        half_sel = lo[1] ? q[31:16] : q[15:0];

        // funct3[2] set selects the unsigned (zero-extending) variants.
        case (funct3[1:0])
            2'd0:    result = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'd1:    result = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: result = q;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32 load/store sequencer in front of the MMU. Parks the
// bus at IDLE_ADDR whenever no access is in flight.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_READ_LATENCY = 1,
    parameter logic [31:0] IDLE_ADDR        = 32'h0
)
(
    input  logic        clock,
    input  logic        RST,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        respValid,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        illegal,
    output logic [31:0] vaddr,
    output logic [31:0] data,
    output logic [3:0]  byteena,
    output logic        memWE,
    input  logic        memWait,
    input  logic [31:0] q,
    output lsu_state_t  fsm_state
);

    localparam logic [2:0] LAT_LOAD = 3'(MEM_READ_LATENCY - 1);

    // Handshake: a request transfers on any clock edge where reqValid and
    // reqReady are both high; reqReady is high exactly while in IDLE. The
    // response is a single respValid pulse that the core must take.
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [1:0]  req_lo;
    logic [2:0]  count;
    logic        acc_illegal;
    logic        acc_misaligned;
    logic [31:0] load_value;

    assign acc_illegal    = is_illegal(reqWrite, funct3);
    assign acc_misaligned = is_misaligned(funct3, addr[1:0]);

    lsu_load_align u_align (
        .q      (q),
        .lo     (req_lo),
        .funct3 (req_funct3),
        .result (load_value)
    );

    always_ff @(posedge clock or posedge RST) begin
        if (RST) begin
            fsm_state  <= IDLE;
            reqReady   <= 1'b1;
            respValid  <= 1'b0;
            rdata      <= 32'h0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
            vaddr      <= IDLE_ADDR;
            data       <= 32'h0;
            byteena    <= 4'b0000;
            memWE      <= 1'b0;
            req_write  <= 1'b0;
            req_funct3 <= 3'd0;
            req_lo     <= 2'd0;
            count      <= 3'd0;
        end else begin
            memWE     <= 1'b0;
            respValid <= 1'b0;
            case (fsm_state)
                IDLE: begin
                    if (reqValid) begin
                        reqReady   <= 1'b0;
                        req_write  <= reqWrite;
                        req_funct3 <= funct3;
                        req_lo     <= addr[1:0];
                        if (acc_illegal || acc_misaligned) begin
                            // Faults answer straight away and never reach the bus.
                            fsm_state  <= RESP;
                            respValid  <= 1'b1;
                            rdata      <= 32'h0;
                            illegal    <= acc_illegal;
                            misaligned <= acc_misaligned && !acc_illegal;
                        end else begin
                            fsm_state <= ACCESS;
                            vaddr     <= addr;
                            byteena   <= lane_mask(funct3, addr[1:0]);
                            data      <= replicate(funct3, wdata);
                            memWE     <= reqWrite;
                        end
                    end
                end
                ACCESS: begin
                    if (!memWait) begin
                        if (req_write) begin
                            fsm_state  <= RESP;
                            respValid  <= 1'b1;
                            rdata      <= 32'h0;
                            misaligned <= 1'b0;
                            illegal    <= 1'b0;
                            vaddr      <= IDLE_ADDR;
                            byteena    <= 4'b0000;
                        end else begin
                            fsm_state <= READ;
                            count     <= LAT_LOAD;
                        end
                    end
                end
                READ: begin
                    if (count == 3'd0) begin
                        fsm_state  <= RESP;
                        respValid  <= 1'b1;
                        rdata      <= load_value;
                        misaligned <= 1'b0;
                        illegal    <= 1'b0;
                        vaddr      <= IDLE_ADDR;
                        byteena    <= 4'b0000;
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                RESP: begin
                    fsm_state <= IDLE;
                    reqReady  <= 1'b1;
                end
                default: begin
                    fsm_state <= IDLE;
                    reqReady  <= 1'b1;
                end
            endcase
        end
    end

endmodule
